// File: rtl/lpc_coefficient_update_if.sv
`default_nettype none
// ============================================================================
// Module   : lpc_coefficient_update_if
// Purpose  : Control, K input and committed-coefficient read bus of the LPC
//            coefficient update block.
// Revision : 1.0
// ============================================================================
interface lpc_coefficient_update_if #(
    parameter int IDX_W = 6
);
    logic             iStart;
    logic [31:0]      iK;
    logic             iClear;
    logic [IDX_W-1:0] iReadIndex;
    logic [31:0]      oCoef;
    logic [IDX_W-1:0] oOrder;
    logic             oBusy;
    logic             oDone;

    modport master (
        output iStart, iK, iClear, iReadIndex,
        input  oCoef, oOrder, oBusy, oDone
    );

    modport slave (
        input  iStart, iK, iClear, iReadIndex,
        output oCoef, oOrder, oBusy, oDone
    );
endinterface
`default_nettype wire

// File: rtl/lpc_coefficient_update.sv
`default_nettype none
// ============================================================================
// Module   : lpc_coefficient_update (with fp_mult, fp_add_sub cores)
// Purpose  : Levinson-Durbin coefficient update a_i' = a_i + K*a_{m+1-i},
//            a_{m+1}' = K, using ping-pong coefficient banks.
// Revision : 1.0
// ============================================================================

// Pipelined float32 multiplier: truncating, flush-to-zero, NaN passthrough.
module fp_mult #(
    parameter int LATENCY = 5
) (
    input  wire logic        clk,
    input  wire logic        i_clk_en,
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    output logic      [31:0] o_result
);
    localparam logic [31:0] c_qnan = 32'h7FC00000;

    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero, w_sign;
    logic [47:0] w_prod;
    logic [22:0] w_mant;
    int          w_exp;
    logic [31:0] w_res;
    logic [31:0] r_pipe [LATENCY];

    assign w_a_nan  = (&i_a[30:23]) && (|i_a[22:0]);
    assign w_b_nan  = (&i_b[30:23]) && (|i_b[22:0]);
    assign w_a_inf  = (&i_a[30:23]) && !(|i_a[22:0]);
    assign w_b_inf  = (&i_b[30:23]) && !(|i_b[22:0]);
    assign w_a_zero = (i_a[30:23] == 8'd0);
    assign w_b_zero = (i_b[30:23] == 8'd0);
    assign w_sign   = i_a[31] ^ i_b[31];
    assign w_prod   = {24'd0, 1'b1, i_a[22:0]} * {24'd0, 1'b1, i_b[22:0]};
    assign w_exp    = int'(i_a[30:23]) + int'(i_b[30:23]) - 127 + (w_prod[47] ? 1 : 0);
    assign w_mant   = 23'(w_prod >> (w_prod[47] ? 24 : 23));

    always_comb begin
        w_res = {w_sign, 8'd0, w_mant};
        if (w_a_nan)
            w_res = i_a;
        else if (w_b_nan)
            w_res = i_b;
        else if (w_a_inf || w_b_inf)
            w_res = (w_a_zero || w_b_zero) ? c_qnan : {w_sign, 8'hFF, 23'd0};
        else if (w_a_zero || w_b_zero || w_exp <= 0)
            w_res = {w_sign, 31'd0};
        else if (w_exp >= 255)
            w_res = {w_sign, 8'hFF, 23'd0};
        else
            w_res = {w_sign, 8'(w_exp), w_mant};
    end

    always_ff @(posedge clk) begin
        if (i_clk_en) begin
            r_pipe[0] <= w_res;
            for (int s = 1; s < LATENCY; s++) r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign o_result = r_pipe[LATENCY-1];
endmodule

// Pipelined float32 adder/subtractor (i_add_sub=1 adds), same number handling.
module fp_add_sub #(
    parameter int LATENCY = 7
) (
    input  wire logic        clk,
    input  wire logic        i_clk_en,
    input  wire logic        i_add_sub,
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    output logic      [31:0] o_result
);
    localparam logic [31:0] c_qnan = 32'h7FC00000;

    logic [31:0] w_bn, w_big, w_small, w_res;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [48:0] w_m_big, w_m_small, w_sum;
    logic [22:0] w_mant;
    int          w_lead, w_exp;
    logic [31:0] r_pipe [LATENCY];

    assign w_bn     = {i_b[31] ^ ~i_add_sub, i_b[30:0]};
    assign w_a_nan  = (&i_a[30:23]) && (|i_a[22:0]);
    assign w_b_nan  = (&i_b[30:23]) && (|i_b[22:0]);
    assign w_a_inf  = (&i_a[30:23]) && !(|i_a[22:0]);
    assign w_b_inf  = (&i_b[30:23]) && !(|i_b[22:0]);
    assign w_a_zero = (i_a[30:23] == 8'd0);
    assign w_b_zero = (i_b[30:23] == 8'd0);
    assign w_big    = (w_bn[30:0] > i_a[30:0]) ? w_bn : i_a;
    assign w_small  = (w_bn[30:0] > i_a[30:0]) ? i_a : w_bn;
    // 24 guard bits below the mantissa keep alignment shifts exact for small gaps
    assign w_m_big   = {2'b01, w_big[22:0], 24'd0};
    assign w_m_small = {2'b01, w_small[22:0], 24'd0} >> (w_big[30:23] - w_small[30:23]);
    assign w_sum     = (w_big[31] == w_small[31]) ? w_m_big + w_m_small : w_m_big - w_m_small;

    always_comb begin
        w_lead = 0;
        for (int k = 0; k < 49; k++) begin
            if (w_sum[k]) w_lead = k;
        end
    end

    assign w_exp  = int'(w_big[30:23]) + w_lead - 47;
    assign w_mant = 23'((w_sum << (48 - w_lead)) >> 25);

    always_comb begin
        w_res = {w_big[31], 8'd0, w_mant};
        if (w_a_nan)
            w_res = i_a;
        else if (w_b_nan)
            w_res = i_b;
        else if (w_a_inf && w_b_inf && (i_a[31] != w_bn[31]))
            w_res = c_qnan;
        else if (w_a_inf)
            w_res = i_a;
        else if (w_b_inf)
            w_res = w_bn;
        else if (w_b_zero)
            w_res = w_a_zero ? w_bn : i_a;
        else if (w_a_zero)
            w_res = w_bn;
        else if (w_sum == 49'd0)
            w_res = 32'd0;
        else if (w_exp <= 0)
            w_res = {w_big[31], 31'd0};
        else if (w_exp >= 255)
            w_res = {w_big[31], 8'hFF, 23'd0};
        else
            w_res = {w_big[31], 8'(w_exp), w_mant};
    end

    always_ff @(posedge clk) begin
        if (i_clk_en) begin
            r_pipe[0] <= w_res;
            for (int s = 1; s < LATENCY; s++) r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign o_result = r_pipe[LATENCY-1];
endmodule

module lpc_coefficient_update #(
    parameter int MAX_ORDER    = 32,
    parameter int IDX_W        = 6,
    parameter int MULT_LATENCY = 5,
    parameter int ADD_LATENCY  = 7
) (
    input  wire logic              iClock,
    input  wire logic              iReset,
    lpc_coefficient_update_if.slave bus
);
    localparam int               c_pipe_i  = MULT_LATENCY + ADD_LATENCY + 2;
    localparam int               c_idx_dly = MULT_LATENCY + ADD_LATENCY + 1;
    localparam int               CNT_W     = $clog2(MAX_ORDER + c_pipe_i + 2) + 1;
    localparam logic [IDX_W-1:0] c_max     = IDX_W'(MAX_ORDER);
    localparam logic [IDX_W-1:0] c_one     = IDX_W'(1);
    localparam logic [CNT_W-1:0] c_pipe    = CNT_W'(c_pipe_i);
    localparam logic [31:0]      c_fp_one  = 32'h3F800000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [31:0]      r_bank [2][2**IDX_W];
    logic             r_sel, r_busy, r_done;
    logic [IDX_W-1:0] r_order, r_m, r_i;
    logic [31:0]      r_k, r_coef;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept, w_commit;
    logic [31:0]      w_coef_next;
    logic [IDX_W-1:0] w_idx_b;

    logic [31:0]      r_rd_a, r_rd_b, r_sum;
    logic [IDX_W-1:0] r_rd_i;
    logic             r_rd_v;
    logic [31:0]      r_a_dly [MULT_LATENCY];
    logic [IDX_W:0]   r_tag_dly [c_idx_dly];
    logic [31:0]      w_prod, w_sum;

    assign w_idx_b = r_m + c_one - r_i;

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.iStart && !r_busy && (r_order < c_max)) begin
                    w_accept     = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if ((r_i == r_m) || (r_m == '0)) w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (r_cnt == CNT_W'(r_m) + c_pipe) begin
                    w_commit     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_coef_next = '0;
        if (bus.iReadIndex == '0)
            w_coef_next = c_fp_one;
        else if (bus.iReadIndex <= r_order)
            w_coef_next = r_bank[r_sel][bus.iReadIndex];
    end

    always_ff @(posedge iClock) begin
        if (iReset || bus.iClear) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
            r_order <= '0;
            r_m     <= '0;
            r_i     <= '0;
            r_k     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_coef  <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_commit;
            r_coef  <= w_coef_next;
            if (w_accept) begin
                r_k    <= bus.iK;
                r_m    <= r_order;
                r_i    <= c_one;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_ISSUE) r_i <= r_i + c_one;
            if (w_commit) begin
                r_sel   <= ~r_sel;
                r_order <= r_m + c_one;
            end
            // busy covers the oDone cycle, then drops
            if (r_done) r_busy <= 1'b0;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset || bus.iClear) begin
            r_rd_v <= 1'b0;
            for (int s = 0; s < c_idx_dly; s++) r_tag_dly[s] <= '0;
        end else if (r_busy) begin
            r_rd_v       <= (r_state == S_ISSUE) && (r_m != '0);
            r_tag_dly[0] <= {r_rd_v, r_rd_i};
            for (int s = 1; s < c_idx_dly; s++) r_tag_dly[s] <= r_tag_dly[s-1];
        end
    end

    always_ff @(posedge iClock) begin
        if (r_busy) begin
            r_rd_a     <= r_bank[r_sel][r_i];
            r_rd_b     <= r_bank[r_sel][w_idx_b];
            r_rd_i     <= r_i;
            r_a_dly[0] <= r_rd_a;
            for (int s = 1; s < MULT_LATENCY; s++) r_a_dly[s] <= r_a_dly[s-1];
            r_sum      <= w_sum;
        end
    end

    // New coefficients only ever land in the inactive bank
    always_ff @(posedge iClock) begin
        if (!iReset && !bus.iClear && r_busy) begin
            if ((r_state == S_ISSUE) && (r_i == c_one))
                r_bank[~r_sel][r_m + c_one] <= r_k;
            if (r_tag_dly[c_idx_dly-1][IDX_W])
                r_bank[~r_sel][r_tag_dly[c_idx_dly-1][IDX_W-1:0]] <= r_sum;
        end
    end

    fp_mult #(
        .LATENCY (MULT_LATENCY)
    ) u_mult (
        .clk      (iClock),
        .i_clk_en (r_busy),
        .i_a      (r_k),
        .i_b      (r_rd_b),
        .o_result (w_prod)
    );

    fp_add_sub #(
        .LATENCY (ADD_LATENCY)
    ) u_add (
        .clk       (iClock),
        .i_clk_en  (r_busy),
        .i_add_sub (1'b1),
        .i_a       (r_a_dly[MULT_LATENCY-1]),
        .i_b       (w_prod),
        .o_result  (w_sum)
    );

    assign bus.oCoef  = r_coef;
    assign bus.oOrder = r_order;
    assign bus.oBusy  = r_busy;
    assign bus.oDone  = r_done;
endmodule
`default_nettype wire

// File: tb/tb_lpc_coefficient_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpc_coefficient_update
// Purpose  : Directed self-checking bench for lpc_coefficient_update.
// Revision : 1.0
// ============================================================================
module tb_lpc_coefficient_update;
    localparam int IDX_W = 6;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    lpc_coefficient_update_if #(.IDX_W(IDX_W)) bus ();

    lpc_coefficient_update #(
        .MAX_ORDER    (32),
        .IDX_W        (IDX_W),
        .MULT_LATENCY (5),
        .ADD_LATENCY  (7)
    ) dut (
        .iClock (clk),
        .iReset (rst),
        .bus    (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_at(input logic [IDX_W-1:0] idx, output logic [31:0] val);
        bus.iReadIndex = idx;
        tick();
        val = bus.oCoef;
    endtask

    // Accept edge is cycle 0; observes cycles 1..60 after it.
    task automatic run_step(input logic [31:0] k, input int restart_at,
                            input logic [IDX_W-1:0] rd_idx, input logic [31:0] coef_exp,
                            output int done_cyc, output int done_cnt, output int busy_end,
                            output bit busy0, output bit coef_ok);
        bus.iReadIndex = rd_idx;
        bus.iK         = k;
        bus.iStart     = 1'b1;
        tick();
        busy0      = bus.oBusy;
        bus.iStart = 1'b0;
        bus.iK     = 32'hDEADBEEF;
        done_cyc = -1;
        done_cnt = 0;
        busy_end = -1;
        coef_ok  = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            bus.iStart = (c == restart_at);
            bus.iK     = (c == restart_at) ? 32'h3F800000 : 32'hDEADBEEF;
            tick();
            if (bus.oDone) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (bus.oBusy) begin
                busy_end = c;
                if (bus.oCoef !== coef_exp) coef_ok = 1'b0;
            end
        end
        bus.iStart = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        bus.iStart = 1'b0; bus.iK = '0; bus.iClear = 1'b0; bus.iReadIndex = '0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        n_checks++; if (bus.oCoef !== 32'h0) $display("FAIL reset_coef: got %h expected %h", bus.oCoef, 32'h0); else n_pass++;
        n_checks++; if (bus.oOrder !== 6'd0) $display("FAIL reset_order: got %0d expected 0", bus.oOrder); else n_pass++;
        n_checks++; if (bus.oBusy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.oBusy); else n_pass++;
        n_checks++; if (bus.oDone !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.oDone); else n_pass++;
        read_at(6'd0, v);
        n_checks++; if (v !== 32'h3F800000) $display("FAIL reset_a0: got %h expected 3f800000", v); else n_pass++;
        read_at(6'd1, v);
        n_checks++; if (v !== 32'h0) $display("FAIL reset_a1: got %h expected 00000000", v); else n_pass++;
        read_at(6'd5, v);
        n_checks++; if (v !== 32'h0) $display("FAIL reset_a5: got %h expected 00000000", v); else n_pass++;
    endtask

    task automatic test_first_step();
        int dc, dn, be; bit b0, ok; logic [31:0] v;
        run_step(32'h3F000000, -1, 6'd1, 32'h0, dc, dn, be, b0, ok);
        n_checks++; if (dc !== 15 || dn !== 1) $display("FAIL step1_done: got cycle %0d count %0d expected cycle 15 count 1", dc, dn); else n_pass++;
        n_checks++; if (b0 !== 1'b1 || be !== 15) $display("FAIL step1_busy: got start %b end %0d expected 1 15", b0, be); else n_pass++;
        n_checks++; if (!ok) $display("FAIL step1_read_during_busy: got changing value expected 00000000"); else n_pass++;
        n_checks++; if (bus.oOrder !== 6'd1) $display("FAIL step1_order: got %0d expected 1", bus.oOrder); else n_pass++;
        read_at(6'd1, v);
        n_checks++; if (v !== 32'h3F000000) $display("FAIL step1_a1: got %h expected 3f000000", v); else n_pass++;
    endtask

    // Also pulses iStart during the oDone cycle, which must be ignored
    task automatic test_second_step();
        int dc, dn, be; bit b0, ok; logic [31:0] v;
        run_step(32'h3E800000, 17, 6'd1, 32'h3F000000, dc, dn, be, b0, ok);
        n_checks++; if (dc !== 16 || dn !== 1) $display("FAIL step2_done: got cycle %0d count %0d expected cycle 16 count 1", dc, dn); else n_pass++;
        n_checks++; if (be !== 16) $display("FAIL step2_busy_end: got %0d expected 16", be); else n_pass++;
        n_checks++; if (!ok) $display("FAIL step2_read_during_busy: got changing value expected 3f000000"); else n_pass++;
        n_checks++; if (bus.oOrder !== 6'd2) $display("FAIL step2_order: got %0d expected 2", bus.oOrder); else n_pass++;
        read_at(6'd1, v);
        n_checks++; if (v !== 32'h3F200000) $display("FAIL step2_a1: got %h expected 3f200000", v); else n_pass++;
        read_at(6'd2, v);
        n_checks++; if (v !== 32'h3E800000) $display("FAIL step2_a2: got %h expected 3e800000", v); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int dc, dn, be; bit b0, ok; logic [31:0] v;
        run_step(32'hBF000000, 5, 6'd1, 32'h3F200000, dc, dn, be, b0, ok);
        n_checks++; if (dc !== 17 || dn !== 1) $display("FAIL step3_done: got cycle %0d count %0d expected cycle 17 count 1", dc, dn); else n_pass++;
        n_checks++; if (!ok) $display("FAIL step3_read_during_busy: got changing value expected 3f200000"); else n_pass++;
        n_checks++; if (bus.oOrder !== 6'd3) $display("FAIL step3_order: got %0d expected 3", bus.oOrder); else n_pass++;
        read_at(6'd1, v);
        n_checks++; if (v !== 32'h3F000000) $display("FAIL step3_a1: got %h expected 3f000000", v); else n_pass++;
        read_at(6'd2, v);
        n_checks++; if (v !== 32'hBD800000) $display("FAIL step3_a2: got %h expected bd800000", v); else n_pass++;
        read_at(6'd3, v);
        n_checks++; if (v !== 32'hBF000000) $display("FAIL step3_a3: got %h expected bf000000", v); else n_pass++;
        read_at(6'd4, v);
        n_checks++; if (v !== 32'h0) $display("FAIL step3_a4: got %h expected 00000000", v); else n_pass++;
    endtask

    task automatic test_abort_reset();
        int dn = 0; logic [31:0] v;
        bus.iK = 32'h3F800000; bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (bus.oDone) dn++;
        end
        n_checks++; if (dn !== 0) $display("FAIL abort_done: got %0d pulses expected 0", dn); else n_pass++;
        n_checks++; if (bus.oOrder !== 6'd0) $display("FAIL abort_order: got %0d expected 0", bus.oOrder); else n_pass++;
        n_checks++; if (bus.oBusy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.oBusy); else n_pass++;
        read_at(6'd1, v);
        n_checks++; if (v !== 32'h0) $display("FAIL abort_a1: got %h expected 00000000", v); else n_pass++;
    endtask

    task automatic test_clear_wins();
        int dc, dn, be, act = 0; bit b0, ok;
        run_step(32'h3F000000, -1, 6'd0, 32'h3F800000, dc, dn, be, b0, ok);
        n_checks++; if (bus.oOrder !== 6'd1) $display("FAIL clear_setup_order: got %0d expected 1", bus.oOrder); else n_pass++;
        bus.iClear = 1'b1; bus.iStart = 1'b1; bus.iK = 32'h3F800000;
        tick();
        bus.iClear = 1'b0; bus.iStart = 1'b0;
        n_checks++; if (bus.oOrder !== 6'd0) $display("FAIL clear_order: got %0d expected 0", bus.oOrder); else n_pass++;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.oBusy || bus.oDone) act++;
        end
        n_checks++; if (act !== 0) $display("FAIL clear_start_ignored: got %0d active cycles expected 0", act); else n_pass++;
    endtask

    task automatic test_max_order();
        int dc, dn, be, bad = 0, act = 0; bit b0, ok; logic [31:0] v;
        for (int j = 0; j < 32; j++) begin
            run_step(32'h0, -1, 6'd0, 32'h3F800000, dc, dn, be, b0, ok);
            if (dc != j + 15 || dn != 1) bad++;
        end
        n_checks++; if (bad !== 0) $display("FAIL max_step_timing: got %0d bad steps expected 0", bad); else n_pass++;
        n_checks++; if (bus.oOrder !== 6'd32) $display("FAIL max_order: got %0d expected 32", bus.oOrder); else n_pass++;
        read_at(6'd32, v);
        n_checks++; if (v !== 32'h0) $display("FAIL max_a32: got %h expected 00000000", v); else n_pass++;
        bus.iK = 32'h3F800000; bus.iStart = 1'b1;
        tick();
        bus.iStart = 1'b0;
        if (bus.oBusy) act++;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (bus.oBusy || bus.oDone) act++;
        end
        n_checks++; if (act !== 0 || bus.oOrder !== 6'd32) $display("FAIL max_start_ignored: got %0d active cycles order %0d expected 0 and 32", act, bus.oOrder); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_first_step();
        test_second_step();
        test_back_to_back();
        test_abort_reset();
        test_clear_wins();
        test_max_order();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
